// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared definitions for the memory-mapped UART: register offsets,
//           STATUS bit positions, TX/RX state encodings, default divisor.
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Register offsets within the 4-word window (addr[1:0])
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_RXDATA  = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_DIVISOR = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_TX_BUSY   = 5;
  localparam int ST_FRAME_ERR = 6;

  localparam logic [15:0] UART_DEFAULT_DIV = 16'd434;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // A divisor below 2 would give a zero-length half bit on RX; clamp it.
  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO. Push on full is accepted only when a pop
//           happens in the same cycle; pop on empty is ignored.
// Rev     : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  // Pointer/count update; pointers wrap naturally because DEPTH is a power of 2
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/mm_uart.sv
`default_nettype none
// ============================================================================
// Module  : mm_uart
// Purpose : Memory-mapped 8N1 UART. Address decode, register file, TX FIFO +
//           serialiser FSM, RX synchroniser + deserialiser FSM + RX FIFO.
// Rev     : 1.0  initial release
// ============================================================================
module mm_uart #(
  parameter logic [15:0] BASE_ADDR   = 16'hC000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = uart_pkg::UART_DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mm_we,
  input  logic        mm_re,
  output logic [15:0] rdata,
  output logic        txd,
  input  logic        rxd
);

  import uart_pkg::*;

  // ---------------- bus decode ----------------
  logic        hit, wr_hit, rd_hit;
  logic [1:0]  off;
  logic [15:0] status;

  assign hit    = (addr[15:2] == BASE_ADDR[15:2]);
  assign wr_hit = mm_we & hit;
  assign rd_hit = mm_re & hit;
  assign off    = addr[1:0];

  // ---------------- FIFOs ----------------
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;

  // ---------------- registers ----------------
  logic [15:0] div_q, div_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;

  tx_state_e   tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_bit_end;
  logic        tx_busy;

  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_bit_end, rx_half_end, rx_fall;
  logic        rx_frame_bad;

  assign tx_push = wr_hit & (off == OFF_TXDATA);
  assign rx_pop  = rd_hit & (off == OFF_RXDATA) & ~rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wdata[7:0]),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_shift_q),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Divisor register and write-1-to-clear sticky bits (a new event wins over a clear)
  always_comb begin
    div_d       = div_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (wr_hit && off == OFF_DIVISOR) div_d = wdata;
    if (wr_hit && off == OFF_STATUS) begin
      if (wdata[ST_OVERRUN])   overrun_d   = 1'b0;
      if (wdata[ST_FRAME_ERR]) frame_err_d = 1'b0;
    end
    if (rx_push && rx_full && !rx_pop) overrun_d   = 1'b1;
    if (rx_frame_bad)                  frame_err_d = 1'b1;
  end

  // STATUS word and load data mux
  always_comb begin
    status               = 16'h0000;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_EMPTY]  = rx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_FRAME_ERR] = frame_err_q;
    rdata                = 16'h0000;
    if (rd_hit) begin
      case (off)
        OFF_RXDATA:  rdata = rx_empty ? 16'h0000 : {8'h00, rx_head};
        OFF_STATUS:  rdata = status;
        OFF_DIVISOR: rdata = div_q;
        default:     rdata = 16'h0000;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  // TX next-state: walk start/data/stop, reloading straight from STOP when more data waits
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_div_d   = tx_div_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_pop     = 1'b0;
    tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = 16'd0;
        if (!tx_empty) tx_pop = 1'b1;
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d   = 16'd0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d   = 16'd0;
          tx_state_d = TX_IDLE;
          if (!tx_empty) tx_pop = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_pop) begin
      tx_shift_d = tx_head;
      tx_div_d   = clamp_div(div_q);
      tx_cnt_d   = 16'd0;
      tx_state_d = TX_START;
    end
  end

  // TX outputs: decoded from state so an async reset drives txd high at once
  always_comb begin
    txd     = 1'b1;
    tx_busy = (tx_state_q != TX_IDLE);
    case (tx_state_q)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_shift_q[0];
      default:  txd = 1'b1;
    endcase
  end

  // ---------------- RX FSM ----------------
  assign rx_fall     = rx_prev_q & ~rx_sync2_q;
  assign rx_bit_end  = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);

  // RX next-state: centre on the start bit, then sample once per bit period
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_div_d   = rx_div_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = 16'd0;
        if (rx_fall) begin
          rx_div_d   = clamp_div(div_q);
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_half_end) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX outputs: stop-bit verdict
  always_comb begin
    rx_push      = 1'b0;
    rx_frame_bad = 1'b0;
    if (rx_state_q == RX_STOP && rx_bit_end) begin
      rx_push      = rx_sync2_q;
      rx_frame_bad = ~rx_sync2_q;
    end
  end

  // All state registers; serial line flops reset to idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= DEFAULT_DIV;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= 8'h00;
      tx_div_q    <= 16'd2;
      tx_cnt_q    <= 16'd0;
      tx_bit_q    <= 3'd0;
      rx_sync1_q  <= 1'b1;
      rx_sync2_q  <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_shift_q  <= 8'h00;
      rx_div_q    <= 16'd2;
      rx_cnt_q    <= 16'd0;
      rx_bit_q    <= 3'd0;
    end else begin
      div_q       <= div_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_div_q    <= tx_div_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      rx_sync1_q  <= rxd;
      rx_sync2_q  <= rx_sync1_q;
      rx_prev_q   <= rx_sync2_q;
      rx_state_q  <= rx_state_d;
      rx_shift_q  <= rx_shift_d;
      rx_div_q    <= rx_div_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
    end
  end

endmodule
`default_nettype wire
